vx_dcache_responder: RTL and testbench
======================================

# VX_dcache_responder

Memory-side responder for the core's per-lane dcache request/response interface: accepts the core's multi-lane requests, serves them from an internal word-addressed memory, and returns one combined response per read batch after a fixed latency. It sits where the dcache normally connects to the pipeline. It is used as a stand-in data memory for pipeline-level benches and for cache-less configurations.

## Interface
Parameters:
- NUM_REQS, `NUM_THREADS: number of request lanes.
- TAG_WIDTH, `DCACHE_CORE_TAG_WIDTH: request/response tag width.
- MEM_ADDR_WIDTH, 10: log2 of memory depth in 32-bit words.
- LATENCY, 2: accept-to-response latency in cycles, legal range ≥ 1.
- RSP_DEPTH, 4: maximum outstanding read batches, legal range ≥ 1.

Ports:
- clk  in  1  clock; the block has one clock.
- reset  in  1  asynchronous, active-high reset.
- dcache_req_valid  in  NUM_REQS  per-lane request valid.
- dcache_req_rw  in  NUM_REQS  per-lane direction: 1 = write, 0 = read.
- dcache_req_byteen  in  NUM_REQS×4  per-lane byte enables; used for writes only.
- dcache_req_addr  in  NUM_REQS×30  per-lane word address.
- dcache_req_data  in  NUM_REQS×32  per-lane write data.
- dcache_req_tag  in  NUM_REQS×TAG_WIDTH  per-lane tag.
- dcache_req_ready  out  NUM_REQS  per-lane ready; all bits are identical.
- dcache_rsp_valid  out  1  response valid.
- dcache_rsp_tmask  out  NUM_REQS  lanes carried by this response.
- dcache_rsp_data  out  NUM_REQS×32  per-lane read data.
- dcache_rsp_tag  out  TAG_WIDTH  response tag.
- dcache_rsp_ready  in  1  core accepts the response.
- busy  out  1  high while any read batch is outstanding.

## Operation
Batches:
- A batch is accepted in any cycle where req_ready is high and any req_valid bit is high.
- req_ready = (outstanding < RSP_DEPTH). It does not depend on req_valid or rw.
- Write-only batches are also blocked while req_ready is low.

Addressing:
- The memory index is addr[MEM_ADDR_WIDTH-1:0]. Upper address bits are ignored, so addresses alias/wrap.

Writes (valid & rw lanes):
- Bytes are updated per byteen at the end of the accept cycle.
- Same word written by several lanes in one batch: for each byte, the highest-indexed lane wins.
- Writes produce no response.

Reads (valid & ~rw lanes):
- Read data is sampled in the accept cycle, before that cycle's writes. A same-cycle read of a written word returns the old data.
- One response entry is formed per batch:
  - tmask = read lanes;
  - data = read words, with non-read lanes driven 0;
  - tag = tag of the lowest-indexed read lane.
- A batch with no read lanes creates no entry.

Credit counter:
- outstanding counts read batches that are accepted but not yet handshaken.
- It increments on a read-batch accept and decrements on rsp_valid & rsp_ready.
- Simultaneous increment and decrement leaves it unchanged.
- Width is clog2(RSP_DEPTH+1).
- busy = (outstanding != 0).

Response path:
- Entries pass through a LATENCY-stage valid/data shift pipeline, then into a RSP_DEPTH-entry FIFO.
- The FIFO head drives the rsp_* outputs.
- The credit counter guarantees the FIFO never overflows, so the pipeline never stalls.
- Responses return in accept order.

Reset:
- Clears the pipeline valids, the FIFO pointers and the credit counter.
- Reset values: dcache_rsp_valid = 0, busy = 0, dcache_req_ready = all ones (after reset deasserts), rsp_tmask/data/tag = 0.
- Memory contents are not reset.
- Reset mid-operation discards all in-flight responses. Writes already committed remain.

## Timing
- Read batch accepted in cycle T with an empty FIFO: rsp_valid is first high in cycle T+LATENCY.
- The response holds stable until the cycle in which rsp_ready is high. The next entry, if present, appears in the following cycle.
- Throughput: one batch per cycle while credits are available. Back-to-back reads with rsp_ready held high sustain one response per cycle.
- With rsp_ready held low: after RSP_DEPTH read batches, req_ready drops in the next cycle. It rises in the cycle after the first response handshake.
- A write in cycle T is visible to a read accepted in cycle T+1.

## Structure
- Response entry type {tmask, data, tag} and the lane/word constants belong in the shared VX_define.vh / VX_gpu_types package.
- Sub-module: the FIFO is an instance of VX_generic_queue (DATAW = NUM_REQS + NUM_REQS·32 + TAG_WIDTH, SIZE = RSP_DEPTH).
- The memory, the merge logic and the credit counter are local to this block.

## Test plan
- Write then read: lane0 write addr 0x10, data 0xDEADBEEF, byteen 0xF. Next cycle, lane0 read addr 0x10, tag 5. Required response: 0xDEADBEEF, tmask 0001, tag 5, returned LATENCY cycles after the read accept.
- Byte merge and priority: lanes 1 and 3 write addr 0x20 in the same batch, byteen 0x3 and 0x6, data 0x11111111 and 0x22222222. A later read of 0x20 returns 0xXX222211. Upper byte: the pre-existing value.
- Mixed batch: lanes 0 and 2 read, lanes 1 and 3 write.
  - Required response: tmask 0101, tag = lane0 tag, data = pre-write values.
  - No response is produced for the write lanes.
- Backpressure: RSP_DEPTH = 4, rsp_ready held 0, five consecutive read batches.
  - Four are accepted, then req_ready = 0 and busy = 1.
  - Releasing rsp_ready drains the responses in order, and the fifth batch is then accepted.
- Reset mid-flight: reset asserted with 2 responses queued.
  - Immediately: rsp_valid = 0, busy = 0.
  - After reset deasserts: req_ready = 1.
  - A read of a previously written word still returns the written data.

Source files
------------

// File: rtl/vx_dcache_responder_pkg.sv
// Shared lane/word constants and helpers for the dcache responder stand-in memory.
// The response entry layout is {tmask, data, tag}; rsp_dataw gives its packed width.
package vx_dcache_responder_pkg;

    localparam int NUM_THREADS           = 4;
    localparam int DCACHE_CORE_TAG_WIDTH = 8;
    localparam int WORD_W                = 32;
    localparam int WORD_BYTES            = WORD_W / 8;
    localparam int WORD_ADDR_W           = 30;

    function automatic int rsp_dataw(input int num_reqs, input int tag_w);
        return num_reqs + num_reqs * WORD_W + tag_w;
    endfunction

endpackage

// File: rtl/vx_dcache_responder_queue.sv
// Circular FIFO holding formed read responses; head is presented combinationally.
// Pointers and occupancy reset; storage does not.
module vx_dcache_responder_queue #(
    parameter int DATAW = 1,
    parameter int SIZE  = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             i_push,
    input  logic             i_pop,
    input  logic [DATAW-1:0] i_data,
    output logic [DATAW-1:0] o_data,
    output logic             o_empty
);

    localparam int PTR_W = (SIZE > 1) ? $clog2(SIZE) : 1;
    localparam int CNT_W = $clog2(SIZE + 1);

    logic [DATAW-1:0] r_store [SIZE];
    logic [PTR_W-1:0] r_rd_ptr;
    logic [PTR_W-1:0] r_wr_ptr;
    logic [CNT_W-1:0] r_count;

    function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(SIZE - 1)) ? '0 : p + 1'b1;
    endfunction

    always_ff @(posedge clk) begin
        if (i_push) r_store[r_wr_ptr] <= i_data;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (i_push) r_wr_ptr <= next_ptr(r_wr_ptr);
            if (i_pop)  r_rd_ptr <= next_ptr(r_rd_ptr);
            case ({i_push, i_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    assign o_data  = r_store[r_rd_ptr];
    assign o_empty = (r_count == '0);

endmodule

// File: rtl/vx_dcache_responder.sv
// Stand-in data memory on the per-lane dcache interface: serves multi-lane batches
// from a word memory and returns one merged response per read batch after LATENCY.
module vx_dcache_responder
    import vx_dcache_responder_pkg::*;
#(
    parameter int NUM_REQS       = NUM_THREADS,
    parameter int TAG_WIDTH      = DCACHE_CORE_TAG_WIDTH,
    parameter int MEM_ADDR_WIDTH = 10,
    parameter int LATENCY        = 2,
    parameter int RSP_DEPTH      = 4
) (
    input  logic                                   clk,
    input  logic                                   reset,
    input  logic [NUM_REQS-1:0]                    dcache_req_valid,
    input  logic [NUM_REQS-1:0]                    dcache_req_rw,
    input  logic [NUM_REQS-1:0][WORD_BYTES-1:0]    dcache_req_byteen,
    input  logic [NUM_REQS-1:0][WORD_ADDR_W-1:0]   dcache_req_addr,
    input  logic [NUM_REQS-1:0][WORD_W-1:0]        dcache_req_data,
    input  logic [NUM_REQS-1:0][TAG_WIDTH-1:0]     dcache_req_tag,
    output logic [NUM_REQS-1:0]                    dcache_req_ready,
    output logic                                   dcache_rsp_valid,
    output logic [NUM_REQS-1:0]                    dcache_rsp_tmask,
    output logic [NUM_REQS-1:0][WORD_W-1:0]        dcache_rsp_data,
    output logic [TAG_WIDTH-1:0]                   dcache_rsp_tag,
    input  logic                                   dcache_rsp_ready,
    output logic                                   busy
);

    localparam int CNT_W     = $clog2(RSP_DEPTH + 1);
    localparam int DATAW     = rsp_dataw(NUM_REQS, TAG_WIDTH);
    localparam int MEM_DEPTH = 1 << MEM_ADDR_WIDTH;

    typedef struct packed {
        logic [NUM_REQS-1:0]             tmask;
        logic [NUM_REQS-1:0][WORD_W-1:0] data;
        logic [TAG_WIDTH-1:0]            tag;
    } rsp_ent_t;

    logic [WORD_W-1:0] r_mem [MEM_DEPTH];
    logic [CNT_W-1:0]  r_outstanding;

    logic                                w_ready;
    logic                                w_accept;
    logic                                w_rd_push;
    logic                                w_rsp_fire;
    logic [NUM_REQS-1:0]                 w_rd_mask;
    logic [NUM_REQS-1:0]                 w_wr_mask;
    logic [NUM_REQS-1:0][MEM_ADDR_WIDTH-1:0] w_idx;
    logic                                w_unused_addr;
    rsp_ent_t                            w_new_ent;
    logic                                w_fifo_push;
    rsp_ent_t                            w_fifo_din;
    logic [DATAW-1:0]                    w_q_dout;
    logic                                w_q_empty;
    rsp_ent_t                            w_head;

    // Credits count read batches still owed a response, so ready ignores the request itself.
    assign w_ready          = (r_outstanding < CNT_W'(RSP_DEPTH));
    assign dcache_req_ready = {NUM_REQS{w_ready}};
    assign w_rd_mask        = dcache_req_valid & ~dcache_req_rw;
    assign w_wr_mask        = dcache_req_valid & dcache_req_rw;
    assign w_accept         = w_ready & (|dcache_req_valid);
    assign w_rd_push        = w_accept & (|w_rd_mask);

    always_comb begin
        w_unused_addr = 1'b0;
        for (int i = 0; i < NUM_REQS; i++) begin
            w_idx[i]      = dcache_req_addr[i][MEM_ADDR_WIDTH-1:0];
            w_unused_addr = w_unused_addr | (^dcache_req_addr[i][WORD_ADDR_W-1:MEM_ADDR_WIDTH]);
        end
    end

    // Reads see the memory before this cycle's writes; walk down so the lowest read lane sets the tag.
    always_comb begin
        w_new_ent       = '0;
        w_new_ent.tmask = w_rd_mask;
        for (int i = NUM_REQS - 1; i >= 0; i--) begin
            if (w_rd_mask[i]) begin
                w_new_ent.data[i] = r_mem[w_idx[i]];
                w_new_ent.tag     = dcache_req_tag[i];
            end
        end
    end

    // Later lanes' byte writes are issued last, so the highest lane wins on collisions.
    always_ff @(posedge clk) begin
        if (w_accept) begin
            for (int i = 0; i < NUM_REQS; i++) begin
                if (w_wr_mask[i]) begin
                    for (int b = 0; b < WORD_BYTES; b++) begin
                        if (dcache_req_byteen[i][b])
                            r_mem[w_idx[i]][8*b +: 8] <= dcache_req_data[i][8*b +: 8];
                    end
                end
            end
        end
    end

    // The FIFO write is the final stage, so only LATENCY-1 explicit register stages are needed.
    if (LATENCY == 1) begin : g_no_pipe
        assign w_fifo_push = w_rd_push;
        assign w_fifo_din  = w_new_ent;
    end else begin : g_pipe
        logic     [LATENCY-2:0] r_vld_pipe;
        rsp_ent_t [LATENCY-2:0] r_ent_pipe;

        always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
                r_vld_pipe <= '0;
            end else begin
                r_vld_pipe[0] <= w_rd_push;
                for (int s = 1; s < LATENCY - 1; s++) r_vld_pipe[s] <= r_vld_pipe[s-1];
            end
        end

        always_ff @(posedge clk) begin
            r_ent_pipe[0] <= w_new_ent;
            for (int s = 1; s < LATENCY - 1; s++) r_ent_pipe[s] <= r_ent_pipe[s-1];
        end

        assign w_fifo_push = r_vld_pipe[LATENCY-2];
        assign w_fifo_din  = r_ent_pipe[LATENCY-2];
    end

    vx_dcache_responder_queue #(
        .DATAW (DATAW),
        .SIZE  (RSP_DEPTH)
    ) u_rsp_q (
        .clk     (clk),
        .reset   (reset),
        .i_push  (w_fifo_push),
        .i_pop   (w_rsp_fire),
        .i_data  (w_fifo_din),
        .o_data  (w_q_dout),
        .o_empty (w_q_empty)
    );

    assign w_head           = w_q_dout;
    assign dcache_rsp_valid = ~w_q_empty;
    assign w_rsp_fire       = dcache_rsp_valid & dcache_rsp_ready;
    assign dcache_rsp_tmask = dcache_rsp_valid ? w_head.tmask : '0;
    assign dcache_rsp_data  = dcache_rsp_valid ? w_head.data  : '0;
    assign dcache_rsp_tag   = dcache_rsp_valid ? w_head.tag   : '0;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_outstanding <= '0;
        end else begin
            case ({w_rd_push, w_rsp_fire})
                2'b10:   r_outstanding <= r_outstanding + 1'b1;
                2'b01:   r_outstanding <= r_outstanding - 1'b1;
                default: r_outstanding <= r_outstanding;
            endcase
        end
    end

    assign busy = (r_outstanding != '0);

endmodule

// File: tb/tb_vx_dcache_responder.sv
// Bench for vx_dcache_responder: directed scenarios plus random batches against a
// queue-and-array reference of the memory and the expected response stream.
module tb_vx_dcache_responder;

    localparam int N     = 4;
    localparam int TW    = 8;
    localparam int MAW   = 10;
    localparam int LAT   = 2;
    localparam int DEPTH = 4;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    logic [N-1:0]         req_valid;
    logic [N-1:0]         req_rw;
    logic [N-1:0][3:0]    req_byteen;
    logic [N-1:0][29:0]   req_addr;
    logic [N-1:0][31:0]   req_data;
    logic [N-1:0][TW-1:0] req_tag;
    logic [N-1:0]         req_ready;
    logic                 rsp_valid;
    logic [N-1:0]         rsp_tmask;
    logic [N-1:0][31:0]   rsp_data;
    logic [TW-1:0]        rsp_tag;
    logic                 rsp_ready;
    logic                 busy;

    vx_dcache_responder #(
        .NUM_REQS(N), .TAG_WIDTH(TW), .MEM_ADDR_WIDTH(MAW), .LATENCY(LAT), .RSP_DEPTH(DEPTH)
    ) dut (
        .clk               (clk),
        .reset             (reset),
        .dcache_req_valid  (req_valid),
        .dcache_req_rw     (req_rw),
        .dcache_req_byteen (req_byteen),
        .dcache_req_addr   (req_addr),
        .dcache_req_data   (req_data),
        .dcache_req_tag    (req_tag),
        .dcache_req_ready  (req_ready),
        .dcache_rsp_valid  (rsp_valid),
        .dcache_rsp_tmask  (rsp_tmask),
        .dcache_rsp_data   (rsp_data),
        .dcache_rsp_tag    (rsp_tag),
        .dcache_rsp_ready  (rsp_ready),
        .busy              (busy)
    );

    int checks   = 0;
    int failures = 0;

    task automatic chk(input string tag, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    // Reference: memory image plus an ordered list of owed responses with their earliest cycle.
    typedef struct {
        logic [N-1:0] tmask;
        logic [127:0] data;
        logic [TW-1:0] tag;
        int           rdy;
    } exp_t;

    logic [31:0] mmem [1024];
    exp_t        q[$];
    int          cyc = 0;

    logic         cap_valid, cap_ready, cap_busy, cap_accept;
    logic [N-1:0] cap_tmask;
    logic [127:0] cap_data;
    logic [TW-1:0] cap_tag;

    task automatic set_idle();
        req_valid = '0; req_rw = '0; req_byteen = '0;
        req_addr = '0; req_data = '0; req_tag = '0;
    endtask

    task automatic set_lane(input int l, input logic rw, input logic [29:0] a,
                            input logic [31:0] d, input logic [3:0] be, input logic [TW-1:0] t);
        req_valid[l] = 1'b1; req_rw[l] = rw; req_addr[l] = a;
        req_data[l] = d; req_byteen[l] = be; req_tag[l] = t;
    endtask

    task automatic cycle_chk();
        logic exp_rdy, exp_vld, found;
        exp_t e;
        @(negedge clk);
        exp_rdy = (q.size() < DEPTH);
        exp_vld = (q.size() > 0) && (q[0].rdy <= cyc);
        cap_valid = rsp_valid; cap_ready = req_ready[0]; cap_busy = busy;
        cap_tmask = rsp_tmask; cap_data = rsp_data; cap_tag = rsp_tag;
        chk("req_ready", req_ready, {N{exp_rdy}});
        chk("busy", busy, q.size() != 0);
        chk("rsp_valid", rsp_valid, exp_vld);
        if (exp_vld && rsp_valid) begin
            chk("rsp_tmask", rsp_tmask, q[0].tmask);
            chk("rsp_data", rsp_data, q[0].data);
            chk("rsp_tag", rsp_tag, q[0].tag);
        end
        if (exp_vld && rsp_ready) void'(q.pop_front());
        cap_accept = exp_rdy && (|req_valid);
        if (cap_accept) begin
            e.tmask = req_valid & ~req_rw; e.data = '0; e.tag = '0; found = 1'b0;
            for (int l = 0; l < N; l++) begin
                if (e.tmask[l]) begin
                    e.data[32*l +: 32] = mmem[req_addr[l][MAW-1:0]];
                    if (!found) e.tag = req_tag[l];
                    found = 1'b1;
                end
            end
            e.rdy = cyc + LAT;
            if (e.tmask != '0) q.push_back(e);
            for (int l = 0; l < N; l++)
                if (req_valid[l] && req_rw[l])
                    for (int b = 0; b < 4; b++)
                        if (req_byteen[l][b])
                            mmem[req_addr[l][MAW-1:0]][8*b +: 8] = req_data[l][8*b +: 8];
        end
        @(posedge clk); #1;
        cyc++;
    endtask

    task automatic drain();
        set_idle(); rsp_ready = 1'b1;
        for (int i = 0; i < 40 && q.size() != 0; i++) cycle_chk();
        chk("drain_empty", q.size() == 0, 1'b1);
    endtask

    initial begin
        reset = 1'b1; rsp_ready = 1'b0;
        set_idle();
        #12;
        chk("rst_rsp_valid", rsp_valid, 1'b0);
        chk("rst_busy", busy, 1'b0);
        chk("rst_tmask", rsp_tmask, '0);
        chk("rst_data", rsp_data, '0);
        chk("rst_tag", rsp_tag, '0);
        @(posedge clk); #1 reset = 1'b0;
        #1 chk("rst_ready", req_ready, {N{1'b1}});

        // Fill words 0..63 with {AB, idx, 5A5A}.
        rsp_ready = 1'b1;
        for (int i = 0; i < 16; i++) begin
            set_idle();
            for (int l = 0; l < N; l++) begin
                logic [7:0] ix;
                ix = 8'(4*i + l);
                set_lane(l, 1'b1, 30'(ix), {8'hAB, ix, 16'h5A5A}, 4'hF, '0);
            end
            cycle_chk();
        end

        // Write then read next cycle.
        set_idle(); set_lane(0, 1'b1, 30'h10, 32'hDEADBEEF, 4'hF, '0); cycle_chk();
        set_idle(); set_lane(0, 1'b0, 30'h10, '0, 4'h0, 8'd5); cycle_chk();
        set_idle(); cycle_chk();
        chk("wr_rd_early", cap_valid, 1'b0);
        cycle_chk();
        chk("wr_rd_valid", cap_valid, 1'b1);
        chk("wr_rd_data", cap_data[31:0], 32'hDEADBEEF);
        chk("wr_rd_tmask", cap_tmask, 4'b0001);
        chk("wr_rd_tag", cap_tag, 8'd5);
        drain();

        // Byte merge with highest lane priority.
        set_idle();
        set_lane(1, 1'b1, 30'h20, 32'h11111111, 4'h3, '0);
        set_lane(3, 1'b1, 30'h20, 32'h22222222, 4'h6, '0);
        cycle_chk();
        set_idle(); set_lane(0, 1'b0, 30'h20, '0, '0, 8'd7); cycle_chk();
        set_idle(); cycle_chk(); cycle_chk();
        chk("merge_data", cap_data[31:0], 32'hAB222211);
        drain();

        // Mixed read/write batch returns pre-write data.
        set_idle();
        set_lane(0, 1'b0, 30'h30, '0, '0, 8'h42);
        set_lane(1, 1'b1, 30'h30, 32'h12345678, 4'hF, 8'h99);
        set_lane(2, 1'b0, 30'h31, '0, '0, 8'h43);
        set_lane(3, 1'b1, 30'h31, 32'h9ABCDEF0, 4'hF, 8'h98);
        cycle_chk();
        set_idle(); cycle_chk(); cycle_chk();
        chk("mixed_tmask", cap_tmask, 4'b0101);
        chk("mixed_tag", cap_tag, 8'h42);
        chk("mixed_data", cap_data, {32'h0, 32'hAB315A5A, 32'h0, 32'hAB305A5A});
        cycle_chk();
        chk("mixed_single_rsp", cap_valid, 1'b0);
        drain();

        // Backpressure: five reads with rsp_ready low.
        rsp_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            set_idle(); set_lane(0, 1'b0, 30'(i), '0, '0, 8'(8'h60 + i)); cycle_chk();
        end
        chk("bp_ready_low", cap_ready, 1'b0);
        chk("bp_busy", cap_busy, 1'b1);
        chk("bp_5th_blocked", cap_accept, 1'b0);
        rsp_ready = 1'b1;
        begin
            logic got;
            got = 1'b0;
            for (int i = 0; i < 20 && !got; i++) begin
                cycle_chk();
                got = cap_accept;
            end
            chk("bp_5th_accept", got, 1'b1);
        end
        drain();

        // Reset with two responses queued.
        rsp_ready = 1'b0;
        set_idle(); set_lane(0, 1'b0, 30'h1, '0, '0, 8'h71); cycle_chk();
        set_idle(); set_lane(2, 1'b0, 30'h2, '0, '0, 8'h72); cycle_chk();
        set_idle(); cycle_chk(); cycle_chk(); cycle_chk();
        chk("pre_rst_valid", cap_valid, 1'b1);
        reset = 1'b1;
        #1;
        chk("midrst_valid", rsp_valid, 1'b0);
        chk("midrst_busy", busy, 1'b0);
        q.delete();
        @(posedge clk); @(posedge clk); #1 reset = 1'b0;
        #1 chk("post_rst_ready", req_ready, {N{1'b1}});
        rsp_ready = 1'b1;
        set_idle(); set_lane(1, 1'b0, 30'h10, '0, '0, 8'h33); cycle_chk();
        set_idle(); cycle_chk(); cycle_chk();
        chk("post_rst_data", cap_data[63:32], 32'hDEADBEEF);
        drain();

        // Random batches over words 0..63 with random upper address bits.
        for (int c = 0; c < 600; c++) begin
            set_idle();
            for (int l = 0; l < N; l++) begin
                if ($urandom_range(0, 2) != 0)
                    set_lane(l, 1'($urandom_range(0, 1)),
                             {20'($urandom), 10'($urandom_range(0, 63))},
                             $urandom, 4'($urandom), 8'($urandom));
            end
            rsp_ready = ($urandom_range(0, 3) != 0);
            cycle_chk();
        end
        drain();
        set_idle(); cycle_chk();
        chk("final_busy", cap_busy, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
